// File: rtl/pc_unit_ras.sv
// Fetch-stage program counter with priority next-PC select and a circular return-address stack.
// Define RAS_STATS_EN to add saturating return hit/miss counters (RasHits, RasMisses).
module pc_unit_ras #(
  parameter int unsigned     WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(32'h00003000),
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(32'h00004180),
  parameter int unsigned     RAS_DEPTH = 4,
  parameter int unsigned     RAS_PTR_W = 2
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Stall,
  input  logic             Exc,
  input  logic             BranchTaken,
  input  logic [WIDTH-1:0] BranchOff,
  input  logic             Jump,
  input  logic [25:0]      JumpIdx,
  input  logic             JumpReg,
  input  logic [WIDTH-1:0] RegTarget,
  input  logic             Link,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PCPlus4,
  output logic [WIDTH-1:0] RasTop,
  output logic             RasEmpty,
  output logic             RasFull,
  output logic             RasMiss
`ifdef RAS_STATS_EN
  ,
  output logic [15:0]      RasHits,
  output logic [15:0]      RasMisses
`endif
);

  localparam int unsigned CNT_W = RAS_PTR_W + 1;

  logic [WIDTH-1:0]     ras_q [RAS_DEPTH];
  logic [RAS_PTR_W-1:0] ptr_q, ptr_d, top_idx, wr_idx;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     pc_d, jump_tgt, wr_data;
  logic                 advance, push, pop;
  logic                 wr_en, ret_eval, miss_d;

  assign PCPlus4  = PC + WIDTH'(4);
  assign top_idx  = ptr_q - RAS_PTR_W'(1);
  assign RasEmpty = (cnt_q == '0);
  assign RasFull  = (cnt_q == CNT_W'(RAS_DEPTH));
  assign RasTop   = RasEmpty ? '0 : ras_q[top_idx];

  // Absolute jump keeps the upper region bits of PC+4 when the PC is wider than 28 bits.
  if (WIDTH > 28) begin : g_jt_wide
    assign jump_tgt = {PCPlus4[WIDTH-1:28], JumpIdx, 2'b00};
  end else begin : g_jt_narrow
    assign jump_tgt = {JumpIdx, 2'b00};
  end

  // Next-PC priority: exception, register jump, taken branch, absolute jump, sequential.
  always_comb begin
    pc_d = PCPlus4;
    if (Exc)              pc_d = EXC_VEC;
    else if (JumpReg)     pc_d = RegTarget;
    else if (BranchTaken) pc_d = PCPlus4 + BranchOff;
    else if (Jump)        pc_d = jump_tgt;
  end

  assign advance = !Stall && !Exc;
  assign push    = advance && Link && (Jump || JumpReg);
  assign pop     = advance && JumpReg;

  // RAS update: a jalr pops and pushes at once, which amounts to rewriting the top entry.
  always_comb begin
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    wr_en    = 1'b0;
    wr_idx   = ptr_q;
    wr_data  = PCPlus4;
    ret_eval = 1'b0;
    miss_d   = 1'b0;

    if (pop) begin
      ret_eval = 1'b1;
      miss_d   = RasEmpty || (RasTop != RegTarget);
    end

    if (pop && push) begin
      wr_en = 1'b1;
      if (RasEmpty) begin
        wr_idx = ptr_q;
        ptr_d  = ptr_q + RAS_PTR_W'(1);
        cnt_d  = CNT_W'(1);
      end else begin
        wr_idx = top_idx;
      end
    end else if (push) begin
      wr_en = 1'b1;
      ptr_d = ptr_q + RAS_PTR_W'(1);
      if (!RasFull) cnt_d = cnt_q + CNT_W'(1);
    end else if (pop && !RasEmpty) begin
      ptr_d = top_idx;
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      PC      <= RESET_VEC;
      ptr_q   <= '0;
      cnt_q   <= '0;
      RasMiss <= 1'b0;
      for (int unsigned i = 0; i < RAS_DEPTH; i++) ras_q[RAS_PTR_W'(i)] <= '0;
    end else begin
      if (!Stall || Exc) PC <= pc_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      RasMiss <= miss_d;
      if (wr_en) ras_q[wr_idx] <= wr_data;
    end
  end

`ifdef RAS_STATS_EN
  // Saturating counters of evaluated returns.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      RasHits   <= '0;
      RasMisses <= '0;
    end else if (ret_eval) begin
      if (miss_d) begin
        if (RasMisses != 16'hFFFF) RasMisses <= RasMisses + 16'd1;
      end else begin
        if (RasHits != 16'hFFFF) RasHits <= RasHits + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pc_unit_ras.sv
// Scoreboard bench for pc_unit_ras: directed stimulus queues expected state, a monitor compares after each edge.
module tb_pc_unit_ras;

  logic        CLK, Reset, Stall, Exc, BranchTaken, Jump, JumpReg, Link;
  logic [31:0] BranchOff, RegTarget;
  logic [25:0] JumpIdx;
  logic [31:0] PC, PCPlus4, RasTop;
  logic        RasEmpty, RasFull, RasMiss;
`ifdef RAS_STATS_EN
  logic [15:0] RasHits, RasMisses;
`endif

  pc_unit_ras dut (
    .CLK(CLK), .Reset(Reset), .Stall(Stall), .Exc(Exc),
    .BranchTaken(BranchTaken), .BranchOff(BranchOff),
    .Jump(Jump), .JumpIdx(JumpIdx), .JumpReg(JumpReg),
    .RegTarget(RegTarget), .Link(Link),
    .PC(PC), .PCPlus4(PCPlus4), .RasTop(RasTop),
    .RasEmpty(RasEmpty), .RasFull(RasFull), .RasMiss(RasMiss)
`ifdef RAS_STATS_EN
    , .RasHits(RasHits), .RasMisses(RasMisses)
`endif
  );

  typedef struct {
    string       nm;
    logic [31:0] pc;
    logic [31:0] top;
    logic        emp;
    logic        full;
    logic        miss;
    logic [15:0] h;
    logic [15:0] m;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_h, exp_m;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
    end
  endtask

  task automatic compare(input exp_t e);
    chk(e.nm, "PC", PC, e.pc);
    chk(e.nm, "PCPlus4", PCPlus4, e.pc + 32'd4);
    chk(e.nm, "RasTop", RasTop, e.top);
    chk(e.nm, "RasEmpty", 32'(RasEmpty), 32'(e.emp));
    chk(e.nm, "RasFull", 32'(RasFull), 32'(e.full));
    chk(e.nm, "RasMiss", 32'(RasMiss), 32'(e.miss));
`ifdef RAS_STATS_EN
    chk(e.nm, "RasHits", 32'(RasHits), 32'(e.h));
    chk(e.nm, "RasMisses", 32'(RasMisses), 32'(e.m));
`endif
  endtask

  function automatic exp_t mk(input string nm, input logic [31:0] pc, input logic [31:0] top,
                              input logic emp, input logic full, input logic miss);
    exp_t e;
    e.nm = nm; e.pc = pc; e.top = top; e.emp = emp; e.full = full; e.miss = miss;
    e.h = exp_h; e.m = exp_m;
    return e;
  endfunction

  task automatic clr();
    Stall = 0; Exc = 0; BranchTaken = 0; BranchOff = '0; Jump = 0;
    JumpIdx = '0; JumpReg = 0; RegTarget = '0; Link = 0;
  endtask

  // Queue the state expected after the coming edge, then advance one cycle.
  task automatic cyc(input string nm, input logic [31:0] pc, input logic [31:0] top,
                     input logic emp, input logic full, input logic miss);
    q.push_back(mk(nm, pc, top, emp, full, miss));
    @(posedge CLK);
    @(negedge CLK);
    clr();
  endtask

  task automatic now_chk(input string nm, input logic [31:0] pc, input logic [31:0] top,
                         input logic emp, input logic full, input logic miss);
    compare(mk(nm, pc, top, emp, full, miss));
  endtask

  task automatic jl(input logic [25:0] idx, input logic lk);
    Jump = 1; JumpIdx = idx; Link = lk;
  endtask

  task automatic jr(input logic [31:0] tgt, input logic lk);
    JumpReg = 1; RegTarget = tgt; Link = lk;
  endtask

  // Monitor: compare every queued expectation just after its clock edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        compare(e);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin : stim
    Reset = 1; clr(); exp_h = 0; exp_m = 0;
    repeat (2) @(negedge CLK);
    now_chk("reset", 32'h3000, 0, 1, 0, 0);
    Reset = 0;

    cyc("seq1", 32'h3004, 0, 1, 0, 0);
    cyc("seq2", 32'h3008, 0, 1, 0, 0);
    cyc("seq3", 32'h300C, 0, 1, 0, 0);
    cyc("seq4", 32'h3010, 0, 1, 0, 0);
    cyc("seq5", 32'h3014, 0, 1, 0, 0);
    Reset = 1; #1;
    now_chk("rst_mid", 32'h3000, 0, 1, 0, 0);
    @(negedge CLK); Reset = 0;
    cyc("rel1", 32'h3004, 0, 1, 0, 0);
    cyc("rel2", 32'h3008, 0, 1, 0, 0);

    jl(26'hC00, 0);                    cyc("j3000", 32'h3000, 0, 1, 0, 0);
    BranchTaken = 1; BranchOff = 32'hFFFFFFF8;
                                       cyc("br_back", 32'h2FFC, 0, 1, 0, 0);
    Exc = 1; jl(26'hC40, 1);           cyc("exc_jmp", 32'h4180, 0, 1, 0, 0);
    jl(26'hC04, 0);                    cyc("j3010", 32'h3010, 0, 1, 0, 0);
    jl(26'hC40, 1);                    cyc("call", 32'h3100, 32'h3014, 0, 0, 0);
    jr(32'h3014, 0); exp_h = 1;        cyc("ret_hit", 32'h3014, 0, 1, 0, 0);

    jl(26'hC00, 0);                    cyc("j3000b", 32'h3000, 0, 1, 0, 0);
    jl(26'hC40, 1);                    cyc("call1", 32'h3100, 32'h3004, 0, 0, 0);
    jl(26'hC80, 1);                    cyc("call2", 32'h3200, 32'h3104, 0, 0, 0);
    jl(26'hCC0, 1);                    cyc("call3", 32'h3300, 32'h3204, 0, 0, 0);
    jl(26'hD00, 1);                    cyc("call4", 32'h3400, 32'h3304, 0, 1, 0);
    jl(26'hD40, 1);                    cyc("call5", 32'h3500, 32'h3404, 0, 1, 0);
    jr(32'h3404, 0); exp_h = 2;        cyc("ret1", 32'h3404, 32'h3304, 0, 0, 0);
    jr(32'h3304, 0); exp_h = 3;        cyc("ret2", 32'h3304, 32'h3204, 0, 0, 0);
    jr(32'h3204, 0); exp_h = 4;        cyc("ret3", 32'h3204, 32'h3104, 0, 0, 0);
    jr(32'h3104, 0); exp_h = 5;        cyc("ret4", 32'h3104, 0, 1, 0, 0);
    jr(32'h3004, 0); exp_m = 1;        cyc("ret_empty", 32'h3004, 0, 1, 0, 1);
                                       cyc("miss_clr", 32'h3008, 0, 1, 0, 0);

    jr(32'h3100, 1); exp_m = 2;        cyc("jalr_empty", 32'h3100, 32'h300C, 0, 0, 1);
    jr(32'h3200, 0); exp_m = 3;        cyc("ret_wrong", 32'h3200, 0, 1, 0, 1);

    jl(26'hCC0, 1);                    cyc("call_s", 32'h3300, 32'h3204, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      Stall = 1; jl(26'hD00, 1);       cyc("stall", 32'h3300, 32'h3204, 0, 0, 0);
    end
    Stall = 1; Exc = 1; jl(26'hD00, 1);
                                       cyc("stall_exc", 32'h4180, 32'h3204, 0, 0, 0);
    Link = 1;                          cyc("link_only", 32'h4184, 32'h3204, 0, 0, 0);
    jl(26'hC40, 1);                    cyc("call_hi", 32'h3100, 32'h4188, 0, 0, 0);
    Exc = 1; jr(32'h4188, 0);          cyc("exc_ret", 32'h4180, 32'h4188, 0, 0, 0);
    jr(32'hFFFFFFFC, 1); exp_m = 4;    cyc("jalr_miss", 32'hFFFFFFFC, 32'h4184, 0, 0, 1);
                                       cyc("wrap", 32'h0, 32'h4184, 0, 0, 0);
    jr(32'h4184, 0); exp_h = 6;        cyc("ret_deep", 32'h4184, 32'h3204, 0, 0, 0);

    Reset = 1; exp_h = 0; exp_m = 0; #1;
    now_chk("rst_stats", 32'h3000, 0, 1, 0, 0);
    @(negedge CLK); Reset = 0;
    jl(26'hC40, 1);                    cyc("s_call1", 32'h3100, 32'h3004, 0, 0, 0);
    jl(26'hC80, 1);                    cyc("s_call2", 32'h3200, 32'h3104, 0, 0, 0);
    jr(32'h3104, 0); exp_h = 1;        cyc("s_ret1", 32'h3104, 32'h3004, 0, 0, 0);
    jr(32'h3004, 0); exp_h = 2;        cyc("s_ret2", 32'h3004, 0, 1, 0, 0);
    jr(32'h3100, 0); exp_m = 1;        cyc("s_ret3", 32'h3100, 0, 1, 0, 1);
                                       cyc("s_seq", 32'h3104, 0, 1, 0, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge CLK);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_unit_ras.md
Name: pc_unit_ras

Overview:
- Parametrised next-generation program counter for the pipeline fetch stage.
- Holds the PC and resolves the next PC by priority: exception, register jump, taken branch, absolute jump, sequential.
- Adds stall and exception redirect.
- Contains a circular return-address stack (RAS) that checks each return target and flags mispredictions.

Parameters:
- WIDTH, 32: PC/data width in bits; must be ≥ 28.
- RESET_VEC, 32'h00003000: PC value loaded on reset.
- EXC_VEC, 32'h00004180: PC value loaded on exception.
- RAS_DEPTH, 4: RAS entries; power of two, 2..16.
- RAS_PTR_W, 2: clog2(RAS_DEPTH).

Ports:
- CLK  in  1  clock; rising edge active.
- Reset  in  1  asynchronous, active-high reset.
- Stall  in  1  hold PC and RAS this cycle.
- Exc  in  1  exception redirect to EXC_VEC.
- BranchTaken  in  1  conditional branch resolved taken.
- BranchOff  in  WIDTH  sign-extended offset, already shifted left 2.
- Jump  in  1  absolute jump (j/jal).
- JumpIdx  in  26  jump instruction index.
- JumpReg  in  1  register jump (jr/jalr).
- RegTarget  in  WIDTH  register jump target.
- Link  in  1  call; push return address.
- PC  out  WIDTH  current PC.
- PCPlus4  out  WIDTH  PC+4, combinational.
- RasTop  out  WIDTH  top-of-stack prediction; 0 when empty.
- RasEmpty  out  1  RAS holds no entries.
- RasFull  out  1  RAS holds RAS_DEPTH entries.
- RasMiss  out  1  registered one-cycle pulse on return mispredict.

Behaviour:
- Reset asserted, asynchronously:
  - PC = RESET_VEC.
  - RAS count = 0, pointer = 0, all entries = 0.
  - RasMiss = 0.
  - RasEmpty = 1, RasFull = 0.
- Next-PC selection, first match wins:
  - Exc → EXC_VEC.
  - JumpReg → RegTarget.
  - BranchTaken → PCPlus4 + BranchOff, modulo 2^WIDTH.
  - Jump → {PCPlus4[WIDTH-1:28], JumpIdx, 2'b00}.
  - Otherwise → PCPlus4.
- PC update: PC loads the selected next-PC on each rising CLK edge. Latency is 1 cycle from inputs to PC.
- Stall:
  - Stall=1 with Exc=0 → PC, RAS and counters hold; RasMiss = 0.
  - Exc overrides Stall; RAS still holds.
- Arithmetic: PC+4 wraps at 2^WIDTH with no flag. Alignment is not checked.
- Push (Link=1 with Jump=1 or JumpReg=1, not stalled, Exc=0):
  - Write PCPlus4 at pointer; pointer+1 modulo depth.
  - count = min(count+1, RAS_DEPTH).
  - Push when full overwrites the oldest entry silently.
- Pop (JumpReg=1 with Link=0, not stalled, Exc=0):
  - Non-empty: compare RasTop with RegTarget; pointer-1, count-1. Next cycle, RasMiss = (RasTop != RegTarget).
  - Empty: state unchanged; next cycle RasMiss = 1.
- jalr (JumpReg=1, Link=1): pop-compare then push in the same cycle.
  - Top entry is replaced by PCPlus4; count unchanged, or 1 if the RAS was empty.
  - Miss is evaluated as for a pop.
- Link without Jump or JumpReg: ignored.
- Exc in the same cycle as Link or JumpReg: no RAS change; RasMiss = 0.
- RasMiss: high for exactly one cycle per mispredicting return; otherwise 0.
- Outputs RasEmpty and RasFull are derived from count.

Optional Feature:
- RAS_STATS_EN defined:
  - Adds outputs RasHits[15:0] and RasMisses[15:0].
  - Each increments on every evaluated return per the rules above.
  - Both saturate at 16'hFFFF.
  - Both clear on Reset.
- Undefined: the counters and their ports do not exist. All other behaviour is identical.

Test Plan:
- Reset mid-run, after 5 sequential cycles → PC = 32'h00003000 immediately. After release: 3004, 3008.
- PC=3000, BranchTaken with BranchOff=32'hFFFFFFF8 → PC=32'h00002FFC next cycle. Assert Exc together with Jump → PC=00004180.
- PC=3010, Jump+Link with JumpIdx=26'h0000C40 → PC=00003100, RasTop=00003014. Then JumpReg with RegTarget=00003014 → PC=00003014, RasMiss stays 0, RasEmpty=1.
- Five calls at PCs 3000/3100/3200/3300/3400 (RAS_DEPTH=4) → RasFull=1. Five returns: first four hit 3404, 3304, 3204, 3104. Fifth (RAS empty) → RasMiss pulse, PC=RegTarget.
- Stall held for 3 cycles during a pending Jump+Link → PC and RasTop unchanged. Exc during Stall → PC=00004180, RAS count unchanged.
- With RAS_STATS_EN defined, 2 hits + 1 miss → RasHits=2, RasMisses=1. Reset → both 0.
